// File: rtl/rst_seq_pkg.sv
// Shared types for the staged reset sequencer.
package rst_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD      = 3'd0,
    ST_RELEASE   = 3'd1,
    ST_RUN       = 3'd2,
    ST_SW_ASSERT = 3'd3,
    ST_SW_WAIT   = 3'd4
  } rst_seq_state_t;

  // Index width for a given number of stages (at least one bit).
  function automatic int unsigned idx_width(input int unsigned stages);
    if (stages > 32'd1) begin
      return $clog2(stages);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Reset-deassertion synchroniser: cleared asynchronously, shifts in a 1 per edge.
module rst_seq_sync #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic sync_o
);

  logic [DEPTH-1:0] sync_q;

  // Shift chain; output goes high on the DEPTH-th edge after rst_n_i release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {DEPTH{1'b0}};
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], 1'b1};
    end
  end

  assign sync_o = sync_q[DEPTH-1];

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: releases STAGES resets in ascending order with a
// programmable per-stage delay, and replays the sequence on a sw request.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned STAGES     = 4,
  parameter int unsigned DLY_W      = 8,
  parameter int unsigned SYNC_DEPTH = 2,
  parameter int unsigned SW_HOLD    = 8
) (
  input  logic                    rst_seq_clk_ip,
  input  logic                    rst_seq_rst_n_ip,
  input  logic [STAGES*DLY_W-1:0] rst_seq_dly_ip,
  input  logic                    rst_seq_sw_req_ip,
  output logic                    rst_seq_sw_ack_op,
  output logic [STAGES-1:0]       rst_seq_rst_op,
  output logic                    rst_seq_done_op,
  output logic [2:0]              rst_seq_state_op
);

  localparam int unsigned IDX_W = idx_width(STAGES);

  logic                 sync_s;
  rst_seq_state_t       state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     idx_inc_s;
  logic [DLY_W-1:0]     cnt_q, cnt_d;
  logic [STAGES-1:0]    rst_q, rst_d;
  logic                 done_q, done_d;
  logic                 ack_q, ack_d;
  logic [DLY_W-1:0]     dly_arr_s [STAGES];

  rst_seq_sync #(
    .DEPTH (SYNC_DEPTH)
  ) u_sync (
    .clk_i   (rst_seq_clk_ip),
    .rst_n_i (rst_seq_rst_n_ip),
    .sync_o  (sync_s)
  );

  for (genvar g = 0; g < STAGES; g++) begin : g_dly
    assign dly_arr_s[g] = rst_seq_dly_ip[g*DLY_W +: DLY_W];
  end

  assign idx_inc_s = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};

  // Next-state logic: stage release walk and the sw request/ack handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    done_d  = done_q;
    ack_d   = ack_q;
    case (state_q)
      ST_HOLD: begin
        if (sync_s) begin
          state_d = ST_RELEASE;
          idx_d   = {IDX_W{1'b0}};
          cnt_d   = dly_arr_s[0];
        end else begin
          rst_d   = {STAGES{1'b1}};
        end
      end
      ST_RELEASE: begin
        if (cnt_q != {DLY_W{1'b0}}) begin
          // Counter only ever decrements from a loaded value, so it cannot wrap.
          cnt_d = cnt_q - {{(DLY_W-1){1'b0}}, 1'b1};
        end else begin
          rst_d[idx_q] = 1'b0;
          if (idx_q < IDX_W'(STAGES-1)) begin
            // The next delay field is sampled here, so edits to later stages apply.
            idx_d = idx_inc_s;
            cnt_d = dly_arr_s[idx_inc_s];
          end else begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (rst_seq_sw_req_ip) begin
          state_d = ST_SW_ASSERT;
          rst_d   = {STAGES{1'b1}};
          done_d  = 1'b0;
          cnt_d   = DLY_W'(SW_HOLD-1);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SW_ASSERT: begin
        if (cnt_q != {DLY_W{1'b0}}) begin
          cnt_d = cnt_q - {{(DLY_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = ST_SW_WAIT;
          ack_d   = 1'b1;
        end
      end
      ST_SW_WAIT: begin
        if (!rst_seq_sw_req_ip) begin
          ack_d   = 1'b0;
          state_d = ST_RELEASE;
          idx_d   = {IDX_W{1'b0}};
          cnt_d   = dly_arr_s[0];
        end else begin
          ack_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_HOLD;
        idx_d   = {IDX_W{1'b0}};
        cnt_d   = {DLY_W{1'b0}};
        rst_d   = {STAGES{1'b1}};
        done_d  = 1'b0;
        ack_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset asserts everything asynchronously.
  always_ff @(posedge rst_seq_clk_ip or negedge rst_seq_rst_n_ip) begin
    if (!rst_seq_rst_n_ip) begin
      state_q <= ST_HOLD;
      idx_q   <= {IDX_W{1'b0}};
      cnt_q   <= {DLY_W{1'b0}};
      rst_q   <= {STAGES{1'b1}};
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  assign rst_seq_rst_op    = rst_q;
  assign rst_seq_done_op   = done_q;
  assign rst_seq_sw_ack_op = ack_q;
  assign rst_seq_state_op  = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed self-checking bench for the staged reset sequencer.
module tb_rst_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] dly;
  logic        sw_req;
  logic        sw_ack;
  logic [3:0]  rst_o;
  logic        done;
  logic [2:0]  state;

  int n_cmp;
  int n_fail;

  rst_seq #(
    .STAGES     (4),
    .DLY_W      (8),
    .SYNC_DEPTH (2),
    .SW_HOLD    (8)
  ) dut (
    .rst_seq_clk_ip    (clk),
    .rst_seq_rst_n_ip  (rst_n),
    .rst_seq_dly_ip    (dly),
    .rst_seq_sw_req_ip (sw_req),
    .rst_seq_sw_ack_op (sw_ack),
    .rst_seq_rst_op    (rst_o),
    .rst_seq_done_op   (done),
    .rst_seq_state_op  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Put the DUT into reset with the default delays and sw_req low.
  task automatic hold_reset();
    rst_n  = 1'b0;
    sw_req = 1'b0;
    dly    = {8'd1, 8'd5, 8'd0, 8'd3};
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    sw_req = 1'b0;
    dly    = {8'd1, 8'd5, 8'd0, 8'd3};
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rst_o !== 4'hF) begin n_fail++; $display("FAIL reset_rst got %h want %h", rst_o, 4'hF); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (sw_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", sw_ack); end
    n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    tick();
    tick();
  endtask

  // Release rst_n between edges and check every edge against falls at 7/8/14/16.
  task automatic test_power_on(input string tag);
    logic [3:0] exp_rst;
    logic [2:0] exp_st;
    rst_n = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      exp_rst = {(e < 16), (e < 14), (e < 8), (e < 7)};
      exp_st  = (e < 3) ? 3'd0 : ((e < 16) ? 3'd1 : 3'd2);
      n_cmp++; if (rst_o !== exp_rst) begin n_fail++; $display("FAIL %s_rst edge %0d got %h want %h", tag, e, rst_o, exp_rst); end
      n_cmp++; if (done !== (e >= 16)) begin n_fail++; $display("FAIL %s_done edge %0d got %b want %b", tag, e, done, (e >= 16)); end
      n_cmp++; if (state !== exp_st) begin n_fail++; $display("FAIL %s_state edge %0d got %0d want %0d", tag, e, state, exp_st); end
    end
  endtask

  task automatic test_async_mid();
    hold_reset();
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) tick();
    n_cmp++; if (rst_o !== 4'hC) begin n_fail++; $display("FAIL mid_pre_rst got %h want %h", rst_o, 4'hC); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rst_o !== 4'hF) begin n_fail++; $display("FAIL mid_async_rst got %h want %h", rst_o, 4'hF); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_async_done got %b want 0", done); end
    n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL mid_async_state got %0d want 0", state); end
    tick();
    tick();
    test_power_on("rerun");
  endtask

  // Sw handshake from RUN, then replay of the release timings.
  task automatic test_sw_req();
    logic [3:0] exp_rst;
    sw_req = 1'b1;
    tick();
    n_cmp++; if (rst_o !== 4'hF) begin n_fail++; $display("FAIL sw_entry_rst got %h want %h", rst_o, 4'hF); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL sw_entry_done got %b want 0", done); end
    n_cmp++; if (state !== 3'd3) begin n_fail++; $display("FAIL sw_entry_state got %0d want 3", state); end
    for (int k = 2; k <= 8; k++) begin
      tick();
      n_cmp++; if (sw_ack !== 1'b0) begin n_fail++; $display("FAIL sw_early_ack E+%0d got %b want 0", k, sw_ack); end
    end
    tick();
    n_cmp++; if (sw_ack !== 1'b1) begin n_fail++; $display("FAIL sw_ack_rise got %b want 1", sw_ack); end
    n_cmp++; if (state !== 3'd4) begin n_fail++; $display("FAIL sw_wait_state got %0d want 4", state); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++; if (sw_ack !== 1'b1) begin n_fail++; $display("FAIL sw_ack_hold %0d got %b want 1", k, sw_ack); end
      n_cmp++; if (rst_o !== 4'hF) begin n_fail++; $display("FAIL sw_hold_rst %0d got %h want %h", k, rst_o, 4'hF); end
    end
    sw_req = 1'b0;
    tick();
    n_cmp++; if (sw_ack !== 1'b0) begin n_fail++; $display("FAIL sw_ack_fall got %b want 0", sw_ack); end
    n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL sw_rel_state got %0d want 1", state); end
    for (int k = 1; k <= 14; k++) begin
      tick();
      exp_rst = {(k < 13), (k < 11), (k < 5), (k < 4)};
      n_cmp++; if (rst_o !== exp_rst) begin n_fail++; $display("FAIL sw_replay_rst F+%0d got %h want %h", k, rst_o, exp_rst); end
      n_cmp++; if (done !== (k >= 13)) begin n_fail++; $display("FAIL sw_replay_done F+%0d got %b want %b", k, done, (k >= 13)); end
    end
  endtask

  // Request held from edge 5 of power-on is serviced only after RUN is reached.
  task automatic test_req_early();
    hold_reset();
    rst_n = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      if (e == 5) sw_req = 1'b1;
      n_cmp++; if (sw_ack !== 1'b0) begin n_fail++; $display("FAIL early_ack edge %0d got %b want 0", e, sw_ack); end
      if (e == 16) begin
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL early_done got %b want 1", done); end
        n_cmp++; if (rst_o !== 4'h0) begin n_fail++; $display("FAIL early_rst16 got %h want 0", rst_o); end
      end
    end
    n_cmp++; if (state !== 3'd3) begin n_fail++; $display("FAIL early_state17 got %0d want 3", state); end
    n_cmp++; if (rst_o !== 4'hF) begin n_fail++; $display("FAIL early_rst17 got %h want %h", rst_o, 4'hF); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL early_done17 got %b want 0", done); end
  endtask

  task automatic test_dly_change();
    logic [3:0] exp_rst;
    // Part A: dly[2] 5->2 while stage 0 counts: falls at 7, 8, 11, 13.
    hold_reset();
    rst_n = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 4) dly[23:16] = 8'd2;
      exp_rst = {(e < 13), (e < 11), (e < 8), (e < 7)};
      n_cmp++; if (rst_o !== exp_rst) begin n_fail++; $display("FAIL dlychg_a edge %0d got %h want %h", e, rst_o, exp_rst); end
    end
    // Part B: dly[2] edited after stage 2 loaded (edge 8): still falls at 14.
    hold_reset();
    rst_n = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 9) dly[23:16] = 8'd1;
      exp_rst = {(e < 16), (e < 14), (e < 8), (e < 7)};
      n_cmp++; if (rst_o !== exp_rst) begin n_fail++; $display("FAIL dlychg_b edge %0d got %h want %h", e, rst_o, exp_rst); end
    end
  endtask

  // Max delay: RELEASE at edge 3, stage 0 at 259, then one edge per stage.
  task automatic test_max_dly();
    hold_reset();
    dly   = {8'd0, 8'd0, 8'd0, 8'd255};
    rst_n = 1'b1;
    for (int e = 1; e <= 262; e++) begin
      tick();
      if (e == 258) begin
        n_cmp++; if (rst_o !== 4'hF) begin n_fail++; $display("FAIL maxdly_258 got %h want %h", rst_o, 4'hF); end
      end
      if (e == 259) begin
        n_cmp++; if (rst_o !== 4'hE) begin n_fail++; $display("FAIL maxdly_259 got %h want %h", rst_o, 4'hE); end
      end
    end
    n_cmp++; if (rst_o !== 4'h0) begin n_fail++; $display("FAIL maxdly_262_rst got %h want 0", rst_o); end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL maxdly_262_done got %b want 1", done); end
    n_cmp++; if (state !== 3'd2) begin n_fail++; $display("FAIL maxdly_262_state got %0d want 2", state); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_power_on("poweron");
    test_sw_req();
    test_async_mid();
    test_req_early();
    test_dly_change();
    test_max_dly();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
